int_div_dispatch: RTL and testbench

Front-end sequencer for the iterative unsigned integer divider. Accepts RV32M-style divide/remainder ops (DIV, DIVU, REM, REMU) on a valid/ready port and converts signed operands to magnitudes. Drives the divider's req/ack port, restores signs on completion, and returns the result with its destination tag on a second valid/ready port. Divide-by-zero and signed overflow are resolved locally and never reach the divider.

---
 rtl/int_div_dispatch.sv | 149 ++++++++++++++
 tb/tb_int_div_dispatch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/int_div_dispatch.sv
// Front-end sequencer for an iterative unsigned divider: RV32M DIV/DIVU/REM/REMU
// with local divide-by-zero/overflow handling. Signed support under INT_DIV_DISPATCH_SIGNED_EN.
module int_div_dispatch #(
    parameter int BITWIDTH = 32,
    parameter int TAGWIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [BITWIDTH-1:0] in_a,
    input  logic [BITWIDTH-1:0] in_b,
    input  logic [TAGWIDTH-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [TAGWIDTH-1:0] out_tag,
    output logic                div_req,
    output logic [BITWIDTH-1:0] div_a,
    output logic [BITWIDTH-1:0] div_b,
    input  logic                div_ack,
    input  logic [BITWIDTH-1:0] div_quotient,
    input  logic [BITWIDTH-1:0] div_remainder
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIXUP, DONE} state_t;

    state_t              state_reg, state_next;
    logic                accept;
    logic                special;
    logic                overflow;
    logic [BITWIDTH-1:0] a_mag, b_mag;
    logic [BITWIDTH-1:0] quo_fix, rem_fix;

    logic                op_rem_reg;
    logic [TAGWIDTH-1:0] tag_reg;
    logic [BITWIDTH-1:0] div_a_reg, div_b_reg;
    logic [BITWIDTH-1:0] quo_reg, rem_reg;
    logic [BITWIDTH-1:0] out_data_reg;

    assign accept  = in_valid && in_ready;
    assign special = (in_b == '0) || overflow;

`ifdef INT_DIV_DISPATCH_SIGNED_EN
    localparam logic [BITWIDTH-1:0] MOST_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};

    logic in_signed, a_neg, b_neg;
    logic q_neg_reg, r_neg_reg;

    assign in_signed = ~in_op[0];
    assign a_neg     = in_signed & in_a[BITWIDTH-1];
    assign b_neg     = in_signed & in_b[BITWIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? -in_a : in_a;
    assign b_mag     = b_neg ? -in_b : in_b;
    assign overflow  = in_signed && (in_a == MOST_NEG) && (in_b == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else if (accept) begin
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
        end
    end

    assign quo_fix = q_neg_reg ? -quo_reg : quo_reg;
    assign rem_fix = r_neg_reg ? -rem_reg : rem_reg;
`else
    logic unused_op_sign;
    assign unused_op_sign = in_op[0];
    assign a_mag    = in_a;
    assign b_mag    = in_b;
    assign overflow = 1'b0;
    assign quo_fix  = quo_reg;
    assign rem_fix  = rem_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = special ? DONE : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_ack) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        div_req   = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            in_ready  = (state_reg == IDLE);
            div_req   = (state_reg == ISSUE);
            out_valid = (state_reg == DONE);
        end
    end

    // Operand capture, special-case results, divider capture and sign restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_rem_reg   <= 1'b0;
            tag_reg      <= '0;
            div_a_reg    <= '0;
            div_b_reg    <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            if (state_reg == IDLE && accept) begin
                op_rem_reg <= in_op[1];
                tag_reg    <= in_tag;
                div_a_reg  <= a_mag;
                div_b_reg  <= b_mag;
                if (in_b == '0) begin
                    out_data_reg <= in_op[1] ? in_a : '1;
                end else if (overflow) begin
                    out_data_reg <= in_op[1] ? '0 : in_a;
                end
            end
            if (state_reg == WAIT && div_ack) begin
                quo_reg <= div_quotient;
                rem_reg <= div_remainder;
            end
            if (state_reg == FIXUP) begin
                out_data_reg <= op_rem_reg ? rem_fix : quo_fix;
            end
        end
    end

    assign out_data = out_data_reg;
    assign out_tag  = tag_reg;
    assign div_a    = div_a_reg;
    assign div_b    = div_b_reg;

endmodule

// File: tb/tb_int_div_dispatch.sv
// Directed bench for int_div_dispatch: behavioural divider, scoreboard queue, immediate assertions.
module tb_int_div_dispatch;
    localparam int BW = 32;
    localparam int TW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [BW-1:0] in_a, in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          div_req;
    logic [BW-1:0] div_a, div_b;
    logic          div_ack;
    logic [BW-1:0] div_quotient, div_remainder;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cnt      = 0;
    logic stray_ack;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t sb_q[$];

    int_div_dispatch #(.BITWIDTH(BW), .TAGWIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .div_req(div_req), .div_a(div_a), .div_b(div_b),
        .div_ack(div_ack), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: ack BW+1 cycles after req, result from currently driven operands.
    always @(posedge clk) begin
        if (div_req) cnt <= BW + 1;
        else if (cnt != 0) cnt <= cnt - 1;
    end
    assign div_ack       = (cnt == 1) || stray_ack;
    assign div_quotient  = stray_ack ? 32'hBAD0BAD0 : ((div_b == 0) ? '1 : div_a / div_b);
    assign div_remainder = stray_ack ? 32'h0BAD0BAD : ((div_b == 0) ? div_a : div_a % div_b);

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] ref_div(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
        int sa, sb;
`ifdef INT_DIV_DISPATCH_SIGNED_EN
        if (!op[0]) begin
            sa = a;
            sb = b;
            if (b == 0) return op[1] ? a : '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
            return op[1] ? sa % sb : sa / sb;
        end
`endif
        if (b == 0) return op[1] ? a : '1;
        return op[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
        if (b == 0) return 1'b1;
`ifdef INT_DIV_DISPATCH_SIGNED_EN
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [BW-1:0] mag_of(input logic [1:0] op, input logic [BW-1:0] x);
`ifdef INT_DIV_DISPATCH_SIGNED_EN
        if (!op[0] && x[BW-1]) return -x;
`endif
        return x;
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [TW-1:0] tag, input int hold, input bit stray);
        logic [BW-1:0] exp_data, da, db;
        bit special;
        int c0, req_cyc, nreq, lat;
        exp_t e;
        exp_data = ref_div(op, a, b);
        special  = is_special(op, a, b);
        sb_q.push_back('{data: exp_data, tag: tag});
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        check("in_ready_before", {31'b0, in_ready}, 32'd1);
        c0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        nreq = 0; req_cyc = -1; lat = -1; da = '0; db = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (div_req) begin nreq++; req_cyc = cyc; da = div_a; db = div_b; end
            if (out_valid) begin lat = cyc - c0; break; end
        end
        check("latency", lat, special ? 32'd1 : BW + 4);
        check("req_count", nreq, special ? 32'd0 : 32'd1);
        if (!special) begin
            check("req_cycle", req_cyc - c0, 32'd1);
            check("div_a", da, mag_of(op, a));
            check("div_b", db, mag_of(op, b));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            stray_ack = stray && (i == 2);
            @(negedge clk);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", out_data, exp_data);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        stray_ack = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid", {31'b0, out_valid}, 32'd1);
        check("sb_nonempty", sb_q.size(), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", {27'b0, out_tag}, {27'b0, e.tag});
        end
        $display("op=%0d a=%h b=%h tag=%0d -> data=%h tag=%0d lat=%0d", op, a, b, tag, out_data, out_tag, lat);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after", {31'b0, in_ready}, 32'd1);
        check("out_valid_after", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b0; stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_div_req", {31'b0, div_req}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", {27'b0, out_tag}, 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(2'b01, 32'd100, 32'd7, 5'd3, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1'b0);
        do_op(2'b00, 32'd5, 32'd0, 5'd6, 0, 1'b0);
        do_op(2'b11, 32'd5, 32'd0, 5'd7, 0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 1'b0);
        do_op(2'b01, 32'd1000, 32'd33, 5'd10, 5, 1'b1);
        do_op(2'b00, 32'h8000_0000, 32'd3, 5'd11, 2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(1, 5000)), 5'(12 + k), 0, 1'b0);
        end

        // Abandon an operation in WAIT, then a late ack while idle.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check("late_ack_out_valid", {31'b0, out_valid}, 32'd0);
        check("late_ack_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(2'b01, 32'd9, 32'd3, 5'd31, 0, 1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
